// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receive path.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_SAMPLE = 8;
    localparam int unsigned DATA_BITS  = 8;

    // Rounded clock divider giving one tick per 1/16 of a bit period.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + 8 * baud) / (16 * baud);
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; shared by the RX and TX paths.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_c,
    output logic                     valid,
    output logic                     full_c,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees a slot.
    assign full_c  = (count == CW'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full_c || do_pop);
    assign head_c  = valid ? mem[rd_ptr] : '0;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CW'(1);
        end
    end

    // Pointers, count and the not-empty flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
        end else begin
            count <= count_next;
            valid <= (count_next != '0);
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Storage array; contents need no reset since valid gates the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, show-ahead receive FIFO and sticky error flags.
// Optional even-parity checking is compiled in with the macro UART_RX_PARITY_EN.
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          rxd,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          framing_err,
    output logic                          overrun_err,
    output logic                          parity_err,
    input  logic                          err_clr
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
    localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned OSW = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    state_t               state;
    logic                 sync1;
    logic                 sync2;
    logic                 prev;
    logic [TW-1:0]        tick_cnt;
    logic [OSW-1:0]       os_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 fall_c;
    logic                 tick_c;
    logic                 mid_c;
    logic                 sample_c;
    logic                 push_c;
    logic                 full_c;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    // Two-flop synchronizer plus edge-detect register, preset to the idle level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rxd;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign fall_c   = prev && !sync2;
    assign tick_c   = (state != IDLE) && (tick_cnt == TW'(DIV - 1));
    assign mid_c    = tick_c && (os_cnt == OSW'(MID_SAMPLE - 1));
    assign sample_c = tick_c && (os_cnt == OSW'(OVERSAMPLE - 1));
`ifdef UART_RX_PARITY_EN
    assign push_c   = (state == STOP) && sample_c && sync2 && !par_bad;
`else
    assign push_c   = (state == STOP) && sample_c && sync2;
`endif

    // Oversample tick divider; parked at zero while idle so it restarts on the start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (state == IDLE || tick_cnt == TW'(DIV - 1)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Frame FSM: start validation, LSB-first data capture, stop check and break wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            os_cnt      <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            // Clear first so that a same-cycle error set overrides it.
            if (err_clr) begin
                framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err  <= 1'b0;
`endif
            end
            if (tick_c) begin
                os_cnt <= os_cnt + OSW'(1);
            end
            case (state)
                IDLE: begin
                    os_cnt <= '0;
                    if (fall_c) begin
                        state <= START;
                    end
                end
                START: begin
                    if (mid_c) begin
                        os_cnt <= '0;
                        if (!sync2) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (sample_c) begin
                        shift <= {sync2, shift[DATA_BITS-1:1]};
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample_c) begin
                        par_bad <= sync2 ^ (^shift);
                        state   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sample_c) begin
                        if (sync2) begin
                            state <= IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end
`endif
                        end else begin
                            framing_err <= 1'b1;
                            state       <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (sync2) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Overrun: a byte arrives while full and nothing is popped in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_err <= 1'b0;
        end else if (push_c && full_c && !rd_en) begin
            overrun_err <= 1'b1;
        end else if (err_clr) begin
            overrun_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_c),
        .push_data (shift),
        .pop       (rd_en),
        .head_c    (rd_data),
        .valid     (rd_valid),
        .full_c    (full_c),
        .count     (fifo_count)
    );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for the FPGA side, paired with the on-chip transmitters that drive the Bluetooth and WiFi module TXD lines on GPIO_1.
- Receives 8N1 frames on a module's RXD pin using 16x oversampling.
- Buffers received bytes in a show-ahead FIFO.
- Reports framing and overrun errors as sticky flags for polling by software through a PIO/bridge wrapper.

Parameters:
- CLK_HZ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- FIFO_DEPTH, 16: receive FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  reset, asynchronous, active-low.
- rxd  in  1  serial input; asynchronous to clk; idles high.
- rd_en  in  1  pop request; acts only while rd_valid=1.
- rd_data  out  8  FIFO head byte; 0 when empty.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  bytes held.
- framing_err  out  1  sticky; stop bit sampled low.
- overrun_err  out  1  sticky; byte dropped because the FIFO was full.
- parity_err  out  1  sticky parity mismatch; tied 0 unless the optional feature is enabled.
- err_clr  in  1  one-cycle pulse clears all sticky errors.

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, synchronizer flops preset to 1. Reset applied mid-frame aborts the frame; no partial byte is pushed.
- rxd passes through a 2-flop synchronizer (2-cycle latency) plus one edge-detect register.
- Tick generator: DIV = (CLK_HZ + 8*BAUD) / (16*BAUD), which gives 27 at the defaults. Counter runs 0..DIV-1 and emits a 1-cycle tick at wrap. It is held at 0 in IDLE and restarts on the start edge.
- FSM:
  - IDLE: falling edge on synced rxd -> START; tick counter and oversample counter cleared.
  - START: after 8 ticks (mid start bit), sample rxd. Low -> DATA with bit index 0. High -> IDLE (treated as a glitch; no error).
  - DATA: every 16 ticks, sample rxd into the shift register LSB-first. After bit 7 -> STOP (or PARITY when the feature is enabled).
  - STOP: after 16 ticks, sample rxd.
    - High: push byte -> IDLE.
    - Low: set framing_err, discard byte -> BREAK.
  - BREAK: wait until synced rxd is high for 1 cycle -> IDLE. A held-low line therefore produces exactly one framing error.
- Push timing: byte is visible (rd_valid=1, rd_data, count updated) on the cycle after the stop-bit sample.
- FIFO behaviour:
  - Show-ahead: rd_data is combinational from the head entry.
  - Pop with rd_en=1 and rd_valid=1 advances the head on the clock edge; rd_en while empty is ignored.
  - Push while full and no pop: byte dropped, overrun_err set, contents unchanged.
  - Simultaneous push and pop while full: both occur, count unchanged, no overrun.
  - Simultaneous push and pop while empty: pop ignored, push accepted.
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally; count range is 0..FIFO_DEPTH.
- Error flags: err_clr and an error set in the same cycle -> the set wins (flag = 1).

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined: an even-parity bit follows bit 7. FSM inserts a PARITY state, sampled 16 ticks after bit 7. Mismatch sets parity_err and drops the byte at STOP, even when the stop bit is good. A framing error takes precedence; in that case only framing_err is set.
- When undefined: no PARITY state, and parity_err is constant 0.

Decomposition:
- Package uart_rx_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK).
  - OVERSAMPLE = 16, MID_SAMPLE = 8, DATA_BITS = 8.
  - Function computing DIV from CLK_HZ and BAUD.
- Sub-module sync_fifo: parameterized width/depth, show-ahead, count output, push/pop with the full/empty rules above. Reusable by the matching TX path.

Test Plan:
1. Send 0xA5 at 115200 baud (bit period 432 clk) -> rd_valid=1, rd_data=0xA5, fifo_count=1 within 4110 cycles of the start edge; pop -> rd_valid=0, rd_data=0.
2. Drive rxd low for 100 cycles, then high -> no push, no error flags, FSM back in IDLE. A following 0x3C frame is received correctly.
3. Send 0x3C with the stop bit forced low and rxd held low for 2 bit times -> framing_err=1, fifo_count=0, exactly one error. Then pulse err_clr -> framing_err=0.
4. Send 0x00..0x10 (17 bytes) with no reads -> fifo_count=16, overrun_err=1. Reads return 0x00..0x0F in order, and then rd_valid=0.
5. FIFO full: assert rd_en on the push cycle of byte 0x55 -> fifo_count stays 16, overrun_err=0, 0x55 read last.
6. Assert reset_n low at data bit 4 of frame 0xFF, release, then send 0x81 -> only 0x81 in FIFO, all flags 0. With UART_RX_PARITY_EN, 0x81 sent with odd parity -> parity_err=1, byte dropped.
